// File: rtl/neighbor_table_writer.sv
// rtl/neighbor_table_writer.sv - inserts or updates one neighbor beacon in the node memory tables
// Searches the neighborID table, then writes the entry; the count word is written last on append.
module neighbor_table_writer #(
  parameter int          MAX_NEIGHBORS = 64,
  parameter logic [15:0] NID_BASE      = 16'h0048,
  parameter logic [15:0] CID_BASE      = 16'h00C8,
  parameter logic [15:0] BATT_BASE     = 16'h0148,
  parameter logic [15:0] QVAL_BASE     = 16'h01C8,
  parameter logic [15:0] NCOUNT_ADDR   = 16'h068A
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pkt_valid,
  output logic        pkt_ready,
  input  logic [15:0] pkt_nid,
  input  logic [15:0] pkt_cid,
  input  logic [15:0] pkt_batt,
  input  logic [15:0] pkt_qval,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  output logic        done,
  output logic [1:0]  status
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_CNT, S_SEARCH, S_WR_NID, S_WR_CID,
    S_WR_BATT, S_WR_QVAL, S_WR_CNT, S_DONE
  } state_t;

  localparam logic [6:0]  MAX_CNT  = 7'(MAX_NEIGHBORS);
  localparam logic [15:0] MAX_WORD = 16'(MAX_NEIGHBORS);

  state_t      state_q, state_d;
  logic [15:0] nid_q, nid_d, cid_q, cid_d, batt_q, batt_d, qval_q, qval_d;
  logic [6:0]  cnt_q, cnt_d, idx_q, idx_d;
  logic        hit_q, hit_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] offset;

  assign offset = {8'd0, idx_q, 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      nid_q    <= '0;
      cid_q    <= '0;
      batt_q   <= '0;
      qval_q   <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      hit_q    <= 1'b0;
      status_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      nid_q    <= nid_d;
      cid_q    <= cid_d;
      batt_q   <= batt_d;
      qval_q   <= qval_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hit_q    <= hit_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    nid_d       = nid_q;
    cid_d       = cid_q;
    batt_d      = batt_q;
    qval_d      = qval_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    status_d    = status_q;
    pkt_ready   = 1'b0;
    mem_address = 16'h0000;
    mem_wr_en   = 1'b0;
    mem_data_in = 16'h0000;
    done        = 1'b0;
    status      = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) begin
          nid_d   = pkt_nid;
          cid_d   = pkt_cid;
          batt_d  = pkt_batt;
          qval_d  = pkt_qval;
          state_d = S_RD_CNT;
        end
      end
      S_RD_CNT: begin
        mem_address = NCOUNT_ADDR;
        // Oversized stored counts are clamped so the table reads as full.
        cnt_d   = (mem_data_out > MAX_WORD) ? MAX_CNT : mem_data_out[6:0];
        idx_d   = 7'd0;
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (idx_q == cnt_q) begin
          hit_d = 1'b0;
          if (cnt_q == MAX_CNT) begin
            status_d = 2'b11;
            state_d  = S_DONE;
          end else begin
            state_d = S_WR_NID;
          end
        end else begin
          mem_address = NID_BASE + offset;
          if (mem_data_out == nid_q) begin
            hit_d   = 1'b1;
            state_d = S_WR_CID;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      S_WR_NID: begin
        mem_wr_en   = 1'b1;
        mem_address = NID_BASE + offset;
        mem_data_in = nid_q;
        state_d     = S_WR_CID;
      end
      S_WR_CID: begin
        mem_wr_en   = 1'b1;
        mem_address = CID_BASE + offset;
        mem_data_in = cid_q;
        state_d     = S_WR_BATT;
      end
      S_WR_BATT: begin
        mem_wr_en   = 1'b1;
        mem_address = BATT_BASE + offset;
        mem_data_in = batt_q;
        state_d     = S_WR_QVAL;
      end
      S_WR_QVAL: begin
        mem_wr_en   = 1'b1;
        mem_address = QVAL_BASE + offset;
        mem_data_in = qval_q;
        if (hit_q) begin
          status_d = 2'b01;
          state_d  = S_DONE;
        end else begin
          state_d = S_WR_CNT;
        end
      end
      S_WR_CNT: begin
        mem_wr_en   = 1'b1;
        mem_address = NCOUNT_ADDR;
        mem_data_in = {9'd0, cnt_q} + 16'd1;
        status_d    = 2'b10;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        status  = status_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A reset arriving mid-entry must not let the current write land.
    if (reset) begin
      pkt_ready = 1'b0;
      mem_wr_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_neighbor_table_writer.sv
// tb/tb_neighbor_table_writer.sv - randomized and directed checks of neighbor_table_writer
// A table-level model predicts writes, status and latency for every accepted beacon.
module tb_neighbor_table_writer;

  localparam logic [15:0] NID_B = 16'h0048;
  localparam logic [15:0] CID_B = 16'h00C8;
  localparam logic [15:0] BAT_B = 16'h0148;
  localparam logic [15:0] QV_B  = 16'h01C8;
  localparam logic [15:0] NC_A  = 16'h068A;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [15:0] pkt_nid = '0, pkt_cid = '0, pkt_batt = '0, pkt_qval = '0;
  logic [15:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_wr_en, done;
  logic [1:0]  status;

  logic [15:0] mem  [0:1023];
  logic [15:0] refm [0:1023];
  logic [31:0] wq [$];

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0, done_cyc = 0;
  int n_acc = 0, n_done = 0;
  int busy = 0, exp_status = 0, exp_lat = 0, last_status = 0, last_lat = 0;

  neighbor_table_writer dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
    .pkt_nid(pkt_nid), .pkt_cid(pkt_cid), .pkt_batt(pkt_batt), .pkt_qval(pkt_qval),
    .mem_address(mem_address), .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .done(done), .status(status)
  );

  always #5 clock = ~clock;

  assign mem_data_out = mem[mem_address[10:1]];
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_wr_en) mem[mem_address[10:1]] = mem_data_in;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rd(input logic [15:0] a);
    return int'(refm[a[10:1]]);
  endfunction

  task automatic add_wr(input logic [15:0] a, input logic [15:0] d);
    wq.push_back({a, d});
    refm[a[10:1]] = d;
  endtask

  // Table semantics: first match in the first min(count,64) entries is updated,
  // otherwise append at index count, or drop when the table is full.
  task automatic predict(input logic [15:0] nid, cid, batt, qval);
    int cnt, hit;
    cnt = rd(NC_A);
    if (cnt > 64) cnt = 64;
    hit = -1;
    for (int i = 0; i < cnt; i++)
      if (rd(NID_B + 16'(2 * i)) == int'(nid)) begin hit = i; break; end
    if (hit >= 0) begin
      add_wr(CID_B + 16'(2 * hit), cid);
      add_wr(BAT_B + 16'(2 * hit), batt);
      add_wr(QV_B + 16'(2 * hit), qval);
      exp_status = 1; exp_lat = hit + 6;
    end else if (cnt == 64) begin
      exp_status = 3; exp_lat = 67;
    end else begin
      add_wr(NID_B + 16'(2 * cnt), nid);
      add_wr(CID_B + 16'(2 * cnt), cid);
      add_wr(BAT_B + 16'(2 * cnt), batt);
      add_wr(QV_B + 16'(2 * cnt), qval);
      add_wr(NC_A, 16'(cnt + 1));
      exp_status = 2; exp_lat = cnt + 8;
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      busy = 0;
      wq.delete();
      chk("wr_en_in_reset", int'(mem_wr_en), 0);
    end else if (busy != 0) begin
      chk("ready_while_busy", int'(pkt_ready), 0);
      if (mem_wr_en) begin
        if (wq.size() == 0) chk("unexpected_write_addr", int'(mem_address), -1);
        else begin
          chk("write_addr", int'(mem_address), int'(wq[0][31:16]));
          chk("write_data", int'(mem_data_in), int'(wq[0][15:0]));
          void'(wq.pop_front());
        end
      end
      if (done) begin
        last_lat = cyc - acc_cyc;
        last_status = int'(status);
        chk("latency", last_lat, exp_lat);
        chk("status", last_status, exp_status);
        chk("writes_left", wq.size(), 0);
        done_cyc = cyc;
        busy = 0;
        n_done++;
      end
    end else begin
      chk("ready_idle", int'(pkt_ready), 1);
      chk("idle_wr_en", int'(mem_wr_en), 0);
      chk("idle_done", int'(done), 0);
      if (pkt_valid && pkt_ready) begin
        predict(pkt_nid, pkt_cid, pkt_batt, pkt_qval);
        acc_cyc = cyc;
        busy = 1;
        n_acc++;
      end
    end
  end

  task automatic setw(input logic [15:0] a, input logic [15:0] d);
    mem[a[10:1]] = d;
    refm[a[10:1]] = d;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin mem[i] = 16'h0; refm[i] = 16'h0; end
  endtask

  task automatic preload_std();
    clear_mem();
    setw(NC_A, 16'd2);
    setw(NID_B, 16'd30); setw(NID_B + 16'd2, 16'd31);
    setw(CID_B, 16'd2);  setw(CID_B + 16'd2, 16'd3);
    setw(BAT_B, 16'd1);  setw(BAT_B + 16'd2, 16'd1);
    setw(QV_B, 16'd5);   setw(QV_B + 16'd2, 16'd7);
  endtask

  task automatic wait_acc(input int a0);
    int t = 0;
    while (n_acc == a0 && t < 20) begin @(posedge clock); #1; t++; end
    if (n_acc == a0) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (n_done == d0 && t < 200) begin @(posedge clock); #1; t++; end
    if (n_done == d0) chk("done_timeout", 0, 1);
  endtask

  task automatic send(input logic [15:0] nid, cid, batt, qval);
    int a0, d0;
    a0 = n_acc; d0 = n_done;
    pkt_nid = nid; pkt_cid = cid; pkt_batt = batt; pkt_qval = qval;
    pkt_valid = 1'b1;
    wait_acc(a0);
    pkt_valid = 1'b0;
    wait_done(d0);
  endtask

  initial begin
    int a0, d0, cnt;
    logic [15:0] nid;
    clear_mem();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_address), 0);
    chk("rst_data", int'(mem_data_in), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_status", int'(status), 0);
    chk("rst_ready", int'(pkt_ready), 0);
    reset = 1'b0;
    #1 chk("ready_after_rst", int'(pkt_ready), 1);

    preload_std();
    send(16'd31, 16'd9, 16'd4, 16'd12);
    chk("t1_cid", int'(mem[16'h00CA >> 1]), 9);
    chk("t1_batt", int'(mem[16'h014A >> 1]), 4);
    chk("t1_qval", int'(mem[16'h01CA >> 1]), 12);
    chk("t1_count", int'(mem[16'h068A >> 1]), 2);
    chk("t1_lat", last_lat, 7);
    chk("t1_status", last_status, 1);

    send(16'd40, 16'd1, 16'd3, 16'd8);
    chk("t2_nid", int'(mem[16'h004C >> 1]), 40);
    chk("t2_cid", int'(mem[16'h00CC >> 1]), 1);
    chk("t2_batt", int'(mem[16'h014C >> 1]), 3);
    chk("t2_qval", int'(mem[16'h01CC >> 1]), 8);
    chk("t2_count", int'(mem[16'h068A >> 1]), 3);
    chk("t2_lat", last_lat, 10);
    chk("t2_status", last_status, 2);

    clear_mem();
    setw(NC_A, 16'd64);
    for (int i = 0; i < 64; i++) setw(NID_B + 16'(2 * i), 16'(1000 + i));
    send(16'd99, 16'd1, 16'd1, 16'd1);
    chk("t3_status", last_status, 3);
    chk("t3_lat", last_lat, 67);
    chk("t3_count", int'(mem[16'h068A >> 1]), 64);
    setw(NC_A, 16'd70);
    send(16'd1063, 16'd5, 16'd6, 16'd7);
    chk("t3_big_hit_lat", last_lat, 69);
    chk("t3_big_count", int'(mem[16'h068A >> 1]), 70);
    send(16'd98, 16'd5, 16'd6, 16'd7);
    chk("t3_big_drop", last_status, 3);

    clear_mem();
    send(16'd7, 16'd2, 16'd3, 16'd4);
    chk("t4_nid", int'(mem[16'h0048 >> 1]), 7);
    chk("t4_count", int'(mem[16'h068A >> 1]), 1);
    chk("t4_status", last_status, 2);
    chk("t4_lat", last_lat, 8);

    preload_std();
    a0 = n_acc; d0 = n_done;
    pkt_nid = 16'd40; pkt_cid = 16'd1; pkt_batt = 16'd3; pkt_qval = 16'd8;
    pkt_valid = 1'b1;
    wait_acc(a0);
    pkt_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("t5_ready", int'(pkt_ready), 1);
    chk("t5_count", int'(mem[16'h068A >> 1]), 2);
    chk("t5_nid_kept", int'(mem[16'h004C >> 1]), 40);
    chk("t5_cid_kept", int'(mem[16'h00CC >> 1]), 1);
    chk("t5_no_done", n_done, d0);
    for (int i = 0; i < 1024; i++) refm[i] = mem[i];

    preload_std();
    @(posedge clock); #1;
    a0 = n_acc; d0 = n_done;
    pkt_nid = 16'd31; pkt_cid = 16'd4; pkt_batt = 16'd4; pkt_qval = 16'd4;
    pkt_valid = 1'b1;
    wait_acc(a0);
    pkt_nid = 16'd50; pkt_cid = 16'd6; pkt_batt = 16'd6; pkt_qval = 16'd6;
    wait_done(d0);
    a0 = n_acc; d0 = n_done;
    wait_acc(a0);
    pkt_valid = 1'b0;
    chk("t6_back_to_back", acc_cyc, done_cyc + 1);
    wait_done(d0);
    chk("t6_nid2", int'(mem[16'h004C >> 1]), 50);
    chk("t6_count", int'(mem[16'h068A >> 1]), 3);

    for (int r = 0; r < 40; r++) begin
      if (r % 10 == 0) begin
        clear_mem();
        cnt = $urandom_range(0, 8);
        setw(NC_A, 16'(cnt));
        for (int i = 0; i < cnt; i++) setw(NID_B + 16'(2 * i), 16'(100 + 3 * i));
      end
      cnt = rd(NC_A);
      if (cnt > 0 && $urandom_range(0, 1) == 1)
        nid = refm[(NID_B[10:1]) + 10'($urandom_range(0, cnt - 1))];
      else
        nid = 16'($urandom_range(90, 140));
      send(nid, 16'($urandom), 16'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clock);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
